// File: rtl/seg_serial_adder.sv
// Multi-cycle adder: SEG bits per clock through one SEG-bit carry segment, with a start/busy/done handshake.
// Define SEG_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seg_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SEG_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / SEG;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic             r_c;
  logic [IW-1:0]    r_idx;

  logic [SEG-1:0]   w_seg_a;
  logic [SEG-1:0]   w_seg_b;
  logic [SEG:0]     w_seg_sum;
  logic [WIDTH-1:0] w_p_next;
`ifdef SEG_SERIAL_ADDER_OVF_EN
  logic             w_ovf;
`endif

  // Current segment add; w_p_next is the partial sum with this segment merged in.
  always_comb begin
    w_seg_a   = r_a[r_idx*SEG +: SEG];
    w_seg_b   = r_b[r_idx*SEG +: SEG];
    w_seg_sum = {1'b0, w_seg_a} + {1'b0, w_seg_b} + {{SEG{1'b0}}, r_c};
    w_p_next  = r_p;
    w_p_next[r_idx*SEG +: SEG] = w_seg_sum[SEG-1:0];
`ifdef SEG_SERIAL_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    w_ovf = (w_seg_sum[SEG-1] ^ w_seg_a[SEG-1] ^ w_seg_b[SEG-1]) ^ w_seg_sum[SEG];
`endif
  end

  // Handshake FSM, segment sequencing and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_p     <= {WIDTH{1'b0}};
      r_c     <= 1'b0;
      r_idx   <= {IW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= {WIDTH{1'b0}};
      cout    <= 1'b0;
`ifdef SEG_SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_idx   <= {IW{1'b0}};
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_p <= w_p_next;
          r_c <= w_seg_sum[SEG];
          if (r_idx == LAST) begin
            s       <= w_p_next;
            cout    <= w_seg_sum[SEG];
`ifdef SEG_SERIAL_ADDER_OVF_EN
            ovf     <= w_ovf;
`endif
            r_idx   <= {IW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          // A start in the done cycle chains straight into the next addition.
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_idx   <= {IW{1'b0}};
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            done    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_adder.sv
// Directed self-checking bench for seg_serial_adder at SEG=4, SEG=1 and SEG=16 (WIDTH=16).
module tb_seg_serial_adder;

  logic        clk;
  logic        rst;
  logic        start4, start1, start16;
  logic [15:0] a, b;
  logic        cin;
  logic        busy4, done4, cout4;
  logic        busy1, done1, cout1;
  logic        busy16, done16, cout16;
  logic [15:0] s4, s1, s16;
`ifdef SEG_SERIAL_ADDER_OVF_EN
  logic        ovf4, ovf1, ovf16;
`endif

  int checks;
  int errors;

  seg_serial_adder #(.WIDTH(16), .SEG(4)) u_seg4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef SEG_SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  seg_serial_adder #(.WIDTH(16), .SEG(1)) u_seg1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
`ifdef SEG_SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  seg_serial_adder #(.WIDTH(16), .SEG(16)) u_seg16 (
    .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16)
`ifdef SEG_SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse on the selected instance; returns just after the accepting edge.
  task automatic launch(input int which, input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a = va; b = vb; cin = vc;
    if (which == 4) start4 = 1'b1;
    else if (which == 1) start1 = 1'b1;
    else start16 = 1'b1;
    tick();
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
  endtask

  // Count edges until done on the selected instance; limit+1 means it never came.
  task automatic wait_done(input int which, input int limit, output int n);
    logic d;
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      d = (which == 4) ? done4 : ((which == 1) ? done1 : done16);
      if (d) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done4); end
    checks++; if (s4 !== 16'h0000) begin errors++; $display("FAIL reset_s got %h exp 0000", s4); end
    checks++; if (cout4 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout4); end
    checks++; if (busy1 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy_other got %b%b exp 00", busy1, busy16); end
  endtask

  task automatic test_carry_ripple();
    launch(4, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL ripple_busy cyc %0d got busy %b done %b exp 1 0", i, busy4, done4); end
      checks++; if (s4 !== 16'h0000) begin errors++; $display("FAIL ripple_s_stable cyc %0d got %h exp 0000", i, s4); end
      if (i < 3) tick();
    end
    tick();
    checks++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL ripple_done got done %b busy %b exp 1 0", done4, busy4); end
    checks++; if (s4 !== 16'h0000 || cout4 !== 1'b1) begin errors++; $display("FAIL ripple_result got %h/%b exp 0000/1", s4, cout4); end
    tick();
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL ripple_done_pulse got %b exp 0", done4); end
  endtask

  task automatic test_hold();
    int n;
    launch(4, 16'h1234, 16'h4321, 1'b1);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
    wait_done(4, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_latency got %0d exp 4", n); end
    checks++; if (s4 !== 16'h5556 || cout4 !== 1'b0) begin errors++; $display("FAIL hold_result got %h/%b exp 5556/0", s4, cout4); end
    tick();
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL hold_done_pulse got %b exp 0", done4); end
    tick(); tick(); tick();
    checks++; if (s4 !== 16'h5556 || busy4 !== 1'b0) begin errors++; $display("FAIL hold_idle got %h busy %b exp 5556 0", s4, busy4); end
  endtask

  task automatic test_ignore_start();
    int pulses;
    launch(4, 16'h00FF, 16'h0001, 1'b0);
    tick();
    a = 16'hAAAA; b = 16'h5555; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL ignore_early_done got %b exp 0", done4); end
    tick();
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL ignore_done got %b exp 1", done4); end
    checks++; if (s4 !== 16'h0100 || cout4 !== 1'b0) begin errors++; $display("FAIL ignore_result got %h/%b exp 0100/0", s4, cout4); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ignore_no_second got %0d exp 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    launch(4, 16'h8000, 16'h8000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy %b done %b exp 0 0", busy4, done4); end
    checks++; if (s4 !== 16'h0000 || cout4 !== 1'b0) begin errors++; $display("FAIL midrst_result got %h/%b exp 0000/0", s4, cout4); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", pulses); end
    launch(4, 16'h0003, 16'h0004, 1'b0);
    wait_done(4, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL midrst_latency got %0d exp 4", n); end
    checks++; if (s4 !== 16'h0007 || cout4 !== 1'b0) begin errors++; $display("FAIL midrst_result2 got %h/%b exp 0007/0", s4, cout4); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(4, 16'h0F0F, 16'h00F1, 1'b0);
    wait_done(4, 20, n);
    checks++; if (n !== 4 || s4 !== 16'h1000) begin errors++; $display("FAIL b2b_first got %0d/%h exp 4/1000", n, s4); end
    launch(4, 16'h0010, 16'h0020, 1'b0);
    checks++; if (busy4 !== 1'b1 || done4 !== 1'b0 || s4 !== 16'h1000) begin errors++; $display("FAIL b2b_restart got busy %b done %b s %h exp 1 0 1000", busy4, done4, s4); end
    wait_done(4, 20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", n); end
    checks++; if (s4 !== 16'h0030 || cout4 !== 1'b0) begin errors++; $display("FAIL b2b_result got %h/%b exp 0030/0", s4, cout4); end
    tick();
  endtask

  task automatic test_seg_extremes();
    int n;
    launch(1, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(1, 40, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL seg1_latency got %0d exp 16", n); end
    checks++; if (s1 !== 16'h0000 || cout1 !== 1'b1) begin errors++; $display("FAIL seg1_result got %h/%b exp 0000/1", s1, cout1); end
    tick();
    launch(16, 16'hFFFF, 16'h0001, 1'b0);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL seg16_busy got %b exp 1", busy16); end
    wait_done(16, 10, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL seg16_latency got %0d exp 1", n); end
    checks++; if (s16 !== 16'h0000 || cout16 !== 1'b1) begin errors++; $display("FAIL seg16_result got %h/%b exp 0000/1", s16, cout16); end
    tick();
    launch(16, 16'hC3A5, 16'h5A5B, 1'b1);
    wait_done(16, 10, n);
    checks++; if (s16 !== 16'h1E01 || cout16 !== 1'b1) begin errors++; $display("FAIL seg16_mixed got %h/%b exp 1e01/1", s16, cout16); end
    tick();
  endtask

`ifdef SEG_SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int n;
    launch(4, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(4, 20, n);
    checks++; if (s4 !== 16'h8000 || cout4 !== 1'b0 || ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_pos got %h/%b/%b exp 8000/0/1", s4, cout4, ovf4); end
    tick();
    launch(4, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(4, 20, n);
    checks++; if (s4 !== 16'h0000 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin errors++; $display("FAIL ovf_wrap got %h/%b/%b exp 0000/1/0", s4, cout4, ovf4); end
    tick();
    launch(1, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(1, 40, n);
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_seg1 got %b exp 1", ovf1); end
    tick();
    launch(16, 16'h8000, 16'h8000, 1'b0);
    wait_done(16, 10, n);
    checks++; if (ovf16 !== 1'b1 || cout16 !== 1'b1) begin errors++; $display("FAIL ovf_seg16 got %b/%b exp 1/1", ovf16, cout16); end
    tick();
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0;
    test_reset();
    test_carry_ripple();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_seg_extremes();
`ifdef SEG_SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
